reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width per register.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2); AW = $clog2(NREGS) derived.
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 CLK  input  1  clock; all state updates on rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 RUrs  input  NRD x AW  read addresses, one per port.
REQ-009 RUout  output  NRD x XLEN  read data, one per port.
REQ-010 RUbusy  output  NRD  scoreboard busy flag of each addressed register.
REQ-011 RUWr  input  1  write enable.
REQ-012 RUrd  input  AW  write address.
REQ-013 RUDatawr  input  XLEN  write data.
REQ-014 RUIss  input  1  issue strobe: marks RUIssrd as pending producer.
REQ-015 RUIssrd  input  AW  destination register of issued instruction.
REQ-016 RUPend  output  AW+1  count of registers currently marked busy.

Function
REQ-017 Register 0 SHALL read as zero on every port, ignore writes, never be marked busy.
REQ-018 When RUWr=1 and RUrd!=0, register RUrd SHALL take RUDatawr at the rising edge; with RUWr=0 no register SHALL change.
REQ-019 Reads SHALL be combinational, zero latency, from array contents.
REQ-020 BYPASS=1: port whose address equals RUrd (non-zero) while RUWr=1 SHALL output RUDatawr in that cycle.
REQ-021 BYPASS=0: such a port SHALL output old contents until the edge.
REQ-022 Scoreboard: RUIss=1, RUIssrd!=0 SHALL set busy[RUIssrd] at the edge.
REQ-023 RUWr=1, RUrd!=0 SHALL clear busy[RUrd] at the edge.
REQ-024 Simultaneous issue and write to same non-zero address: busy SHALL end set (new producer wins); data still written.
REQ-025 Simultaneous issue and write to different addresses: both SHALL take effect.
REQ-026 Issue to already-busy register SHALL keep it busy, RUPend unchanged.
REQ-027 Write to a non-busy register SHALL update data, busy stays clear.
REQ-028 RUbusy[i] SHALL reflect registered busy of RUrs[i]; BYPASS=1 and RUrs[i]==RUrd with RUWr=1 SHALL force RUbusy[i]=0.
REQ-029 RUPend SHALL equal population count of busy vector, registered, updated same edge as busy; range 0..NREGS-1, no wrap.

Reset
REQ-030 RST=1 at an edge SHALL clear all registers to 0, all busy bits to 0, RUPend to 0.
REQ-031 RST SHALL dominate RUWr and RUIss in the same cycle.
REQ-032 Reset mid-operation SHALL drop all pending busy marks; first write after release behaves as REQ-018.
REQ-033 Outputs after reset: RUout = 0 all ports, RUbusy = 0, RUPend = 0.

Structure
REQ-034 Shared package rf_pkg SHALL hold default XLEN, NREGS, NRD constants and the zero-register index constant.
REQ-035 Scoreboard (busy vector, set/clear priority, RUPend counter) SHALL be sub-module rf_scoreboard; data array and bypass stay in top.
REQ-036 Read ports SHALL be generated by a loop over NRD; no per-port hand-coding.

Verification
REQ-037 Reset, then read all addresses on both ports -> all 0, RUbusy=0, RUPend=0.
REQ-038 Write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-039 BYPASS=1: write 0xA5A5A5A5 to r7 while port1 reads r7 -> same-cycle output 0xA5A5A5A5; BYPASS=0 -> old value.
REQ-040 Issue r3, r9 on consecutive cycles -> RUPend 1 then 2; write r3 -> RUbusy(r3)=0, RUPend=1.
REQ-041 Same cycle issue r4 and write r4 = 0x55 -> r4=0x55, busy(r4)=1, RUPend +1.
REQ-042 Issue r2, r6, r8, assert RST with RUWr=1 to r2 -> r2=0, RUPend=0, all busy clear.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry
// and the index of the hard-wired zero register.
package rf_pkg;
    localparam int unsigned RF_XLEN     = 32;
    localparam int unsigned RF_NREGS    = 32;
    localparam int unsigned RF_NRD      = 2;
    localparam int unsigned RF_ZERO_REG = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between a pipeline front end (master) and the register file
// (slave): read ports, write port, issue port and scoreboard status.
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NRD   = RF_NRD
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   RUrs;
    logic [NRD-1:0][XLEN-1:0] RUout;
    logic [NRD-1:0]           RUbusy;
    logic                     RUWr;
    logic [AW-1:0]            RUrd;
    logic [XLEN-1:0]          RUDatawr;
    logic                     RUIss;
    logic [AW-1:0]            RUIssrd;
    logic [AW:0]              RUPend;

    modport master (
        output RUrs, RUWr, RUrd, RUDatawr, RUIss, RUIssrd,
        input  RUout, RUbusy, RUPend
    );

    modport slave (
        input  RUrs, RUWr, RUrd, RUDatawr, RUIss, RUIssrd,
        output RUout, RUbusy, RUPend
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per register plus a
// registered count of flags set. Index 0 can never be marked busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS = RF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_idx,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_idx,
    output logic [NREGS-1:0] o_busy,
    output logic [AW:0]      o_pend
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_pend;
    logic [AW:0]      w_pend_nxt;

    // Next busy vector: completion clears first, then issue sets, so a new producer wins on a shared index.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
        w_busy_nxt[0] = 1'b0;
        w_pend_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            w_pend_nxt = w_pend_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    // Busy vector and its population count update on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= '0;
            r_pend <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign o_busy = r_busy;
    assign o_pend = r_pend;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, optional same-cycle
// write forwarding, and a busy scoreboard for in-flight producers.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter int unsigned NRD    = RF_NRD,
    parameter int unsigned BYPASS = 1
) (
    input  logic         CLK,
    input  logic         RST,
    reg_file_sb_if.slave bus
);
    localparam int unsigned   AW       = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_IDX = AW'(RF_ZERO_REG);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic                     w_wr_en;
    logic                     w_iss_en;
    logic [NREGS-1:0]         w_busy;
    logic [NRD-1:0][XLEN-1:0] w_rout;
    logic [NRD-1:0]           w_rbusy;

    assign w_wr_en  = bus.RUWr  && (bus.RUrd    != ZERO_IDX);
    assign w_iss_en = bus.RUIss && (bus.RUIssrd != ZERO_IDX);

    // Data array: reset clears every entry; entry 0 is never written so it stays zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.RUrd] <= bus.RUDatawr;
        end
    end

    // A forwarded port sees the incoming data and a cleared busy flag in the write cycle.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_rs;
        logic          w_fwd;
        assign w_rs       = bus.RUrs[g];
        assign w_fwd      = (BYPASS != 0) && w_wr_en && (w_rs == bus.RUrd);
        assign w_rout[g]  = (w_rs == ZERO_IDX) ? '0 :
                            w_fwd              ? bus.RUDatawr : r_regs[w_rs];
        assign w_rbusy[g] = w_busy[w_rs] && !w_fwd;
    end

    assign bus.RUout  = w_rout;
    assign bus.RUbusy = w_rbusy;

    rf_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .CLK       (CLK),
        .RST       (RST),
        .i_set_en  (w_iss_en),
        .i_set_idx (bus.RUIssrd),
        .i_clr_en  (w_wr_en),
        .i_clr_idx (bus.RUrd),
        .o_busy    (w_busy),
        .o_pend    (bus.RUPend)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one forwarding and one non-forwarding instance
// driven in lockstep and compared against a behavioural register model.
module tb_reg_file_sb;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) if1 ();
    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) if0 ();

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_b1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1.slave)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_dut_b0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0.slave)
    );

    // Reference model state and the inputs currently applied.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          c_rst, c_wr, c_iss;
    logic [4:0]  c_rd, c_issrd;
    logic [31:0] c_data;
    logic [4:0]  c_rs [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit fwd_hit(input bit byp, input logic [4:0] a);
        return byp && c_wr && (c_rd != 0) && (c_rd == a);
    endfunction

    function automatic logic [31:0] exp_out(input bit byp, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (fwd_hit(byp, a)) return c_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input bit byp, input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (fwd_hit(byp, a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_pend();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Register-transfer rules: reset wipes everything; a write retires its
    // destination; an issue then marks its destination pending.
    task automatic model_edge();
        if (c_rst) begin
            model_reset();
        end else begin
            if (c_wr && c_rd != 0) begin
                m_regs[c_rd] = c_data;
                m_busy[c_rd] = 1'b0;
            end
            if (c_iss && c_issrd != 0) m_busy[c_issrd] = 1'b1;
        end
    endtask

    task automatic drive(input bit rst, input bit wr, input int rd, input logic [31:0] data,
                         input bit iss, input int issrd, input int rs0, input int rs1);
        c_rst = rst; c_wr = wr; c_rd = 5'(rd); c_data = data;
        c_iss = iss; c_issrd = 5'(issrd); c_rs[0] = 5'(rs0); c_rs[1] = 5'(rs1);
        RST = rst;
        if1.RUWr = wr; if1.RUrd = c_rd; if1.RUDatawr = data;
        if1.RUIss = iss; if1.RUIssrd = c_issrd;
        if1.RUrs[0] = c_rs[0]; if1.RUrs[1] = c_rs[1];
        if0.RUWr = wr; if0.RUrd = c_rd; if0.RUDatawr = data;
        if0.RUIss = iss; if0.RUIssrd = c_issrd;
        if0.RUrs[0] = c_rs[0]; if0.RUrs[1] = c_rs[1];
    endtask

    task automatic check_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("b1_out%0d r%0d", p, c_rs[p]), 64'(if1.RUout[p]), 64'(exp_out(1'b1, c_rs[p])));
            chk($sformatf("b0_out%0d r%0d", p, c_rs[p]), 64'(if0.RUout[p]), 64'(exp_out(1'b0, c_rs[p])));
            chk($sformatf("b1_busy%0d r%0d", p, c_rs[p]), 64'(if1.RUbusy[p]), 64'(exp_busy(1'b1, c_rs[p])));
            chk($sformatf("b0_busy%0d r%0d", p, c_rs[p]), 64'(if0.RUbusy[p]), 64'(exp_busy(1'b0, c_rs[p])));
        end
        chk("b1_pend", 64'(if1.RUPend), 64'(exp_pend()));
        chk("b0_pend", 64'(if0.RUPend), 64'(exp_pend()));
    endtask

    // One clock: compare mid-cycle, advance the model at the edge.
    task automatic cycle();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < 32; a += 2) begin
            drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, a, a + 1);
            cycle();
        end
        chk("rst_pend", 64'(if1.RUPend), 64'd0);

        // Plain write then read; write to r0 is discarded.
        drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 5, 0);
        #1 chk("r5_read", 64'(if1.RUout[0]), 64'hDEADBEEF);
        cycle();
        drive(1'b0, 1'b1, 0, 32'h1234, 1'b0, 0, 0, 0);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        #1 chk("r0_zero", 64'(if1.RUout[0]), 64'h0);
        cycle();

        // Same-cycle forwarding versus old contents.
        drive(1'b0, 1'b1, 7, 32'h11111111, 1'b0, 0, 0, 0);
        cycle();
        drive(1'b0, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 0, 0, 7);
        #1 chk("byp1_r7", 64'(if1.RUout[1]), 64'hA5A5A5A5);
        chk("byp0_r7", 64'(if0.RUout[1]), 64'h11111111);
        cycle();

        // Issue r3, r9; retire r3.
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 3, 9);
        cycle();
        chk("pend_1", 64'(if1.RUPend), 64'd1);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 9, 3, 9);
        cycle();
        chk("pend_2", 64'(if1.RUPend), 64'd2);
        drive(1'b0, 1'b1, 3, 32'h33, 1'b0, 0, 3, 9);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 3, 9);
        #1 chk("r3_free", 64'(if1.RUbusy[0]), 64'd0);
        chk("pend_after_wr", 64'(if1.RUPend), 64'd1);
        cycle();

        // Issue and write the same register together: new producer wins.
        drive(1'b0, 1'b1, 4, 32'h55, 1'b1, 4, 0, 0);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 4, 0);
        #1 chk("r4_data", 64'(if1.RUout[0]), 64'h55);
        chk("r4_busy", 64'(if1.RUbusy[0]), 64'd1);
        chk("pend_r4", 64'(if1.RUPend), 64'd2);
        cycle();

        // Reset in the middle of outstanding issues, with a write pending.
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 2, 2, 6);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 6, 2, 6);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 8, 2, 8);
        cycle();
        chk("pend_5", 64'(if1.RUPend), 64'd5);
        drive(1'b1, 1'b1, 2, 32'hFFFF, 1'b1, 2, 2, 6);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 2, 6);
        #1 chk("rst_r2", 64'(if1.RUout[0]), 64'h0);
        chk("rst_busy_r6", 64'(if1.RUbusy[1]), 64'd0);
        chk("rst_pend0", 64'(if1.RUPend), 64'd0);
        cycle();
        drive(1'b0, 1'b1, 2, 32'h77, 1'b0, 0, 0, 0);
        cycle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 2, 0);
        #1 chk("r2_after_rst", 64'(if1.RUout[0]), 64'h77);
        cycle();

        // Randomised traffic with deliberate address collisions.
        for (int n = 0; n < 400; n++) begin
            int rd, rs0, rs1, issrd;
            rd    = int'($urandom_range(0, 31));
            rs0   = ($urandom_range(0, 2) == 0) ? rd : int'($urandom_range(0, 31));
            rs1   = ($urandom_range(0, 2) == 0) ? rd : int'($urandom_range(0, 31));
            issrd = ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), rd, $urandom(),
                  1'($urandom_range(0, 1)), issrd, rs0, rs1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
